issue_control_unit: RTL and testbench

Issue controller between the decode unit and the execution units. It accepts one decoded micro-op per cycle through a valid/ready handshake. It holds the micro-op in a registered issue slot and dispatches it to the INT, BRU, LSU or VEC unit with a per-unit valid/ready handshake. It also tracks register hazards with a scoreboard and sequences the fetch halt after branches and invalid instructions.

---
 rtl/issue_control_unit.sv | 161 ++++++++++++++++
 tb/tb_issue_control_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_control_unit.sv
// issue_control_unit: issue stage between decode and the INT/BRU/LSU/VEC units.
// One registered issue slot with per-unit valid/ready dispatch, a RUN/HALT/EXCEPT
// sequencer for fetch halts, and an optional register scoreboard.
// Optional feature macro: CORE101_SCOREBOARD_EN (busy bits + hazard check).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and the payload is held stable while valid
// is high and ready is low.
module issue_control_unit #(
   parameter int HALT_CNT_W = 4
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  dec_valid_in,
   output logic                  dec_ready_out,
   input  logic [2:0]            dec_exec_sel_in,
   input  logic [3:0]            dec_uop_in,
   input  logic [4:0]            dec_rd_in,
   input  logic [4:0]            dec_rs1_in,
   input  logic [4:0]            dec_rs2_in,
   input  logic                  dec_rd_we_in,
   input  logic                  dec_pc_mux_sel_in,
   input  logic                  dec_imm_mux_sel_in,
   input  logic                  dec_halt_in,
   input  logic [HALT_CNT_W-1:0] dec_halt_count_in,
   output logic [3:0]            issue_valid_out,
   input  logic [3:0]            issue_ready_in,
   output logic [3:0]            issue_uop_out,
   output logic [4:0]            issue_rd_out,
   output logic                  issue_pc_mux_sel_out,
   output logic                  issue_imm_mux_sel_out,
   input  logic                  wb_valid_in,
   input  logic [4:0]            wb_rd_in,
   output logic                  ifu_halt_out,
   output logic                  exception_out,
   input  logic                  exception_clear_in,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_EXCEPT = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [HALT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  slot_valid_q;
   logic [3:0]            slot_unit_q;
   logic [3:0]            unit_oh;
   logic                  fire, free, hazard;
   logic                  accept, accept_ok, accept_bad;

   // Translate the decode unit code into the one-hot issue lane; zero = invalid.
   always_comb begin
      unit_oh = 4'b0000;
      case (dec_exec_sel_in)
         3'b001:  unit_oh = 4'b0001;
         3'b011:  unit_oh = 4'b0010;
         3'b010:  unit_oh = 4'b0100;
         3'b100:  unit_oh = 4'b1000;
         default: unit_oh = 4'b0000;
      endcase
   end

   assign issue_valid_out = slot_valid_q ? slot_unit_q : 4'b0000;
   assign fire            = |(issue_valid_out & issue_ready_in);
   assign free            = !slot_valid_q | fire;

   // Gated by reset_in so the combinational outputs read 0 while reset is held.
   assign dec_ready_out = reset_in & (state_q == ST_RUN) & free & !hazard;
   assign accept        = dec_valid_in & dec_ready_out;
   assign accept_ok     = accept & (unit_oh != 4'b0000);
   assign accept_bad    = accept & (unit_oh == 4'b0000);

   assign ifu_halt_out  = reset_in & ((state_q != ST_RUN) | (dec_valid_in & !dec_ready_out));
   assign exception_out = (state_q == ST_EXCEPT);
   assign dbg_state     = state_q;

`ifdef CORE101_SCOREBOARD_EN
   logic [31:0] busy_q;
   logic [31:0] busy_eff;

   // Busy view used for the hazard check: a register completing this cycle is free.
   always_comb begin
      busy_eff = busy_q;
      if (wb_valid_in) busy_eff[wb_rd_in] = 1'b0;
      busy_eff[0] = 1'b0;
   end

   assign hazard = busy_eff[dec_rs1_in] | busy_eff[dec_rs2_in] |
                   (dec_rd_we_in & busy_eff[dec_rd_in]);

   // Scoreboard update: writeback clears first, a new writer sets last so it wins.
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         busy_q <= '0;
      end else begin
         if (wb_valid_in && (wb_rd_in != 5'd0)) busy_q[wb_rd_in] <= 1'b0;
         if (accept_ok && dec_rd_we_in && (dec_rd_in != 5'd0)) busy_q[dec_rd_in] <= 1'b1;
      end
   end
`else
   logic unused_sb;
   assign unused_sb = ^{wb_valid_in, wb_rd_in, dec_rs1_in, dec_rs2_in, dec_rd_we_in};
   assign hazard    = 1'b0;
`endif

   // Issue slot: load on a valid accept, empty on a completed dispatch, else hold.
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         slot_valid_q          <= 1'b0;
         slot_unit_q           <= 4'b0000;
         issue_uop_out         <= 4'b0000;
         issue_rd_out          <= 5'd0;
         issue_pc_mux_sel_out  <= 1'b0;
         issue_imm_mux_sel_out <= 1'b0;
      end else if (accept_ok) begin
         slot_valid_q          <= 1'b1;
         slot_unit_q           <= unit_oh;
         issue_uop_out         <= dec_uop_in;
         issue_rd_out          <= dec_rd_in;
         issue_pc_mux_sel_out  <= dec_pc_mux_sel_in;
         issue_imm_mux_sel_out <= dec_imm_mux_sel_in;
      end else if (fire) begin
         slot_valid_q          <= 1'b0;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sequencer next state: branch halts count down, bad unit codes park in EXCEPT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (accept_bad) begin
               state_d = ST_EXCEPT;
            end else if (accept_ok && dec_halt_in) begin
               state_d = ST_HALT;
               cnt_d   = dec_halt_count_in;
            end
         end
         ST_HALT: begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_EXCEPT: begin
            if (exception_clear_in) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_issue_control_unit.sv
// tb_issue_control_unit: directed bench for issue_control_unit. A per-cycle
// vector table covers back-to-back issue, branch halts, exceptions and unit
// back-pressure; hand-written sequences cover reset and register hazards.
module tb_issue_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dec_valid;
   logic       dec_ready;
   logic [2:0] dec_sel;
   logic [3:0] dec_uop;
   logic [4:0] dec_rd, dec_rs1, dec_rs2;
   logic       dec_we, dec_pc, dec_imm, dec_halt;
   logic [3:0] dec_cnt;
   logic [3:0] iss_valid, iss_ready, iss_uop;
   logic [4:0] iss_rd;
   logic       iss_pc, iss_imm;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       ifu_halt, exc, exc_clr;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];

   // Clock and DUT
   always #5 clk = ~clk;

   issue_control_unit #(.HALT_CNT_W(4)) dut (
      .clock_in(clk), .reset_in(rst_n),
      .dec_valid_in(dec_valid), .dec_ready_out(dec_ready),
      .dec_exec_sel_in(dec_sel), .dec_uop_in(dec_uop),
      .dec_rd_in(dec_rd), .dec_rs1_in(dec_rs1), .dec_rs2_in(dec_rs2),
      .dec_rd_we_in(dec_we), .dec_pc_mux_sel_in(dec_pc), .dec_imm_mux_sel_in(dec_imm),
      .dec_halt_in(dec_halt), .dec_halt_count_in(dec_cnt),
      .issue_valid_out(iss_valid), .issue_ready_in(iss_ready),
      .issue_uop_out(iss_uop), .issue_rd_out(iss_rd),
      .issue_pc_mux_sel_out(iss_pc), .issue_imm_mux_sel_out(iss_imm),
      .wb_valid_in(wb_valid), .wb_rd_in(wb_rd),
      .ifu_halt_out(ifu_halt), .exception_out(exc),
      .exception_clear_in(exc_clr), .dbg_state(dbg_state)
   );

   typedef struct {
      logic       v;
      logic [2:0] sel;
      logic [3:0] uop;
      logic       halt;
      logic [3:0] cnt;
      logic [3:0] rdy;
      logic       clr;
      logic       e_ready;
      logic [3:0] e_iv;
      logic       e_halt;
      logic       e_exc;
      logic [3:0] e_uop;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [3:0] uop,
                               input logic halt, input logic [3:0] cnt, input logic [3:0] rdy,
                               input logic clr, input logic e_ready, input logic [3:0] e_iv,
                               input logic e_halt, input logic e_exc, input logic [3:0] e_uop);
      vec_t r;
      r.v = v; r.sel = sel; r.uop = uop; r.halt = halt; r.cnt = cnt; r.rdy = rdy; r.clr = clr;
      r.e_ready = e_ready; r.e_iv = e_iv; r.e_halt = e_halt; r.e_exc = e_exc; r.e_uop = e_uop;
      return r;
   endfunction

   function automatic logic sel_ok(input logic [2:0] s);
      return (s == 3'b001) || (s == 3'b011) || (s == 3'b010) || (s == 3'b100);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic set_in(input logic v, input logic [2:0] sel, input logic [3:0] uop,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic we, input logic wbv, input logic [4:0] wbr);
      dec_valid = v; dec_sel = sel; dec_uop = uop; dec_rd = rd;
      dec_rs1 = rs1; dec_rs2 = rs2; dec_we = we;
      dec_pc = uop[0]; dec_imm = uop[1]; dec_halt = 1'b0; dec_cnt = 4'd0;
      wb_valid = wbv; wb_rd = wbr; exc_clr = 1'b0; iss_ready = 4'b1111;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b1, 3'b001, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

      // Reset held two cycles with a pending micro-op
      #3;
      chk("rst_ready_c0", dec_ready, 0);
      chk("rst_halt_c0", ifu_halt, 0);
      tick();
      #3;
      chk("rst_ready_c1", dec_ready, 0);
      chk("rst_halt_c1", ifu_halt, 0);
      chk("rst_iv", iss_valid, 0);
      chk("rst_exc", exc, 0);
      chk("rst_uop", iss_uop, 0);
      chk("rst_rd", iss_rd, 0);
      chk("rst_pc", iss_pc, 0);
      chk("rst_imm", iss_imm, 0);
      tick();
      rst_n = 1'b1;
      #3;
      chk("rel_ready", dec_ready, 1);
      chk("rel_halt", ifu_halt, 0);
      tick();
      set_in(1'b0, 3'b000, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      #3;
      chk("rel_iv", iss_valid, 4'b0001);
      tick();

      // Reset in the middle of a stalled dispatch discards the slot
      set_in(1'b1, 3'b010, 4'd12, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      iss_ready = 4'b0000;
      #3;
      chk("mid_accept", dec_ready, 1);
      tick();
      dec_valid = 1'b0;
      #3;
      chk("mid_iv_before", iss_valid, 4'b0100);
      chk("mid_uop_before", iss_uop, 12);
      rst_n = 1'b0;
      #1;
      chk("mid_ready_in_rst", dec_ready, 0);
      tick();
      rst_n = 1'b1;
      #3;
      chk("mid_iv_after", iss_valid, 0);
      chk("mid_uop_after", iss_uop, 0);
      iss_ready = 4'b1111;

      // Per-cycle vector table (rd = uop, pc/imm = uop bits 0/1, no register writes)
      tbl[0]  = mk(1, 3'b001, 4'd1,  0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd0);
      tbl[1]  = mk(1, 3'b001, 4'd2,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd1);
      tbl[2]  = mk(1, 3'b100, 4'd3,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd2);
      tbl[3]  = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h8, 0, 0, 4'd3);
      tbl[4]  = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd3);
      tbl[5]  = mk(1, 3'b011, 4'd4,  1, 2, 4'hF, 0, 1, 4'h0, 0, 0, 4'd3);
      tbl[6]  = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 0, 4'h2, 1, 0, 4'd4);
      tbl[7]  = mk(1, 3'b001, 4'd5,  0, 0, 4'hF, 0, 0, 4'h0, 1, 0, 4'd4);
      tbl[8]  = mk(1, 3'b001, 4'd5,  0, 0, 4'hF, 0, 0, 4'h0, 1, 0, 4'd4);
      tbl[9]  = mk(1, 3'b001, 4'd5,  0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd4);
      tbl[10] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd5);
      tbl[11] = mk(1, 3'b000, 4'd6,  0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd5);
      tbl[12] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 0, 4'h0, 1, 1, 4'd5);
      tbl[13] = mk(1, 3'b001, 4'd7,  0, 0, 4'hF, 0, 0, 4'h0, 1, 1, 4'd5);
      tbl[14] = mk(1, 3'b001, 4'd7,  0, 0, 4'hF, 1, 0, 4'h0, 1, 1, 4'd5);
      tbl[15] = mk(1, 3'b001, 4'd7,  0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd5);
      tbl[16] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd7);
      tbl[17] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 1, 1, 4'h0, 0, 0, 4'd7);
      tbl[18] = mk(1, 3'b010, 4'd8,  0, 0, 4'hB, 0, 1, 4'h0, 0, 0, 4'd7);
      tbl[19] = mk(1, 3'b001, 4'd9,  0, 0, 4'hB, 0, 0, 4'h4, 1, 0, 4'd8);
      tbl[20] = mk(1, 3'b001, 4'd9,  0, 0, 4'hB, 0, 0, 4'h4, 1, 0, 4'd8);
      tbl[21] = mk(1, 3'b001, 4'd9,  0, 0, 4'hB, 0, 0, 4'h4, 1, 0, 4'd8);
      tbl[22] = mk(1, 3'b001, 4'd9,  0, 0, 4'hB, 0, 0, 4'h4, 1, 0, 4'd8);
      tbl[23] = mk(1, 3'b001, 4'd9,  0, 0, 4'hF, 0, 1, 4'h4, 0, 0, 4'd8);
      tbl[24] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd9);
      tbl[25] = mk(1, 3'b011, 4'd10, 1, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd9);
      tbl[26] = mk(1, 3'b001, 4'd11, 0, 0, 4'hF, 0, 0, 4'h2, 1, 0, 4'd10);
      tbl[27] = mk(1, 3'b001, 4'd11, 0, 0, 4'hF, 0, 1, 4'h0, 0, 0, 4'd10);
      tbl[28] = mk(0, 3'b000, 4'd0,  0, 0, 4'hF, 0, 1, 4'h1, 0, 0, 4'd11);

      for (int i = 0; i < 29; i++) begin
         set_in(tbl[i].v, tbl[i].sel, tbl[i].uop, {1'b0, tbl[i].uop}, 5'd0, 5'd0,
                1'b0, 1'b0, 5'd0);
         dec_halt = tbl[i].halt; dec_cnt = tbl[i].cnt;
         iss_ready = tbl[i].rdy; exc_clr = tbl[i].clr;
         #3;
         chk($sformatf("t%0d_ready", i), dec_ready, tbl[i].e_ready);
         chk($sformatf("t%0d_iv", i), iss_valid, tbl[i].e_iv);
         chk($sformatf("t%0d_ifu_halt", i), ifu_halt, tbl[i].e_halt);
         chk($sformatf("t%0d_exc", i), exc, tbl[i].e_exc);
         chk($sformatf("t%0d_uop", i), iss_uop, tbl[i].e_uop);
         chk($sformatf("t%0d_rd", i), iss_rd, {1'b0, tbl[i].e_uop});
         chk($sformatf("t%0d_pc", i), iss_pc, tbl[i].e_uop[0]);
         chk($sformatf("t%0d_imm", i), iss_imm, tbl[i].e_uop[1]);
         // Scoreboard: dispatches must come out in acceptance order
         if ((tbl[i].e_iv & tbl[i].rdy) != 4'b0000) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("t%0d_q_nonempty", i), 0, 1);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               chk($sformatf("t%0d_q_uop", i), iss_uop, e);
            end
         end
         if (tbl[i].v && tbl[i].e_ready && sel_ok(tbl[i].sel)) exp_q.push_back(tbl[i].uop);
         tick();
      end
      chk("q_drained", exp_q.size(), 0);

`ifdef CORE101_SCOREBOARD_EN
      // RAW hazard on x5, resolved by a same-cycle writeback
      set_in(1, 3'b001, 4'd1, 5'd5, 5'd0, 5'd0, 1, 0, 5'd0); #3;
      chk("h1_ready", dec_ready, 1); tick();
      set_in(1, 3'b001, 4'd2, 5'd6, 5'd5, 5'd0, 1, 0, 5'd0); #3;
      chk("h2_ready", dec_ready, 0); chk("h2_halt", ifu_halt, 1); chk("h2_iv", iss_valid, 1);
      tick();
      set_in(1, 3'b001, 4'd2, 5'd6, 5'd5, 5'd0, 1, 0, 5'd0); #3;
      chk("h3_ready", dec_ready, 0); chk("h3_halt", ifu_halt, 1); tick();
      set_in(1, 3'b001, 4'd2, 5'd6, 5'd5, 5'd0, 1, 1, 5'd5); #3;
      chk("h4_ready", dec_ready, 1); chk("h4_halt", ifu_halt, 0); tick();
      set_in(0, 3'b000, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd6); #3;
      chk("h5_iv", iss_valid, 1); chk("h5_uop", iss_uop, 2); tick();
      // Set and clear of x7 in the same cycle: the set wins
      set_in(1, 3'b001, 4'd3, 5'd7, 5'd0, 5'd0, 1, 0, 5'd0); #3;
      chk("h6_ready", dec_ready, 1); tick();
      set_in(1, 3'b001, 4'd4, 5'd7, 5'd0, 5'd0, 1, 1, 5'd7); #3;
      chk("h7_ready", dec_ready, 1); tick();
      set_in(1, 3'b001, 4'd5, 5'd0, 5'd7, 5'd0, 0, 0, 5'd0); #3;
      chk("h8_ready", dec_ready, 0); chk("h8_iv", iss_valid, 1); chk("h8_uop", iss_uop, 4);
      tick();
      set_in(1, 3'b001, 4'd5, 5'd0, 5'd0, 5'd7, 0, 0, 5'd0); #3;
      chk("h9_ready_rs2", dec_ready, 0); tick();
      set_in(1, 3'b001, 4'd5, 5'd0, 5'd7, 5'd0, 0, 1, 5'd7); #3;
      chk("h10_ready", dec_ready, 1); tick();
      set_in(0, 3'b000, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0); #3;
      chk("h11_uop", iss_uop, 5); tick();
      // x0 is never busy
      set_in(1, 3'b001, 4'd6, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0); #3;
      chk("h12_ready", dec_ready, 1); tick();
      set_in(1, 3'b001, 4'd7, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0); #3;
      chk("h13_ready_x0", dec_ready, 1); tick();
      set_in(0, 3'b000, 4'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0); #3;
      chk("h14_uop", iss_uop, 7); tick();
`else
      // Without a scoreboard a dependent reader issues immediately
      set_in(1, 3'b001, 4'd1, 5'd5, 5'd0, 5'd0, 1, 0, 5'd0); #3;
      chk("n1_ready", dec_ready, 1); tick();
      set_in(1, 3'b001, 4'd2, 5'd6, 5'd5, 5'd5, 1, 0, 5'd0); #3;
      chk("n2_ready", dec_ready, 1); chk("n2_halt", ifu_halt, 0); chk("n2_iv", iss_valid, 1);
      tick();
      set_in(0, 3'b000, 4'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd5); #3;
      chk("n3_iv", iss_valid, 1); chk("n3_uop", iss_uop, 2); chk("n3_ready", dec_ready, 1);
      tick();
      #3;
      chk("n4_iv", iss_valid, 0); tick();
`endif

      // Final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
